// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-deep holding register for gapless frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  bus,
    output logic      tx,
    output logic      tx_busy
);
    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    logic       accept;
    logic       bit_end;
    logic       load;
    logic [7:0] load_data;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
`ifdef UART_TX_PARITY_EN
        par_d       = par_q;
`endif
        accept    = bus.tx_valid && !hold_full_q;
        bit_end   = (cnt_q == CNT_LAST);
        load      = 1'b0;
        load_data = bus.tx_data;

        if (state_q == S_IDLE) begin
            load = accept;
        end else begin
            cnt_d = bit_end ? '0 : cnt_q + CW'(1);
            if (accept) begin
                hold_d      = bus.tx_data;
                hold_full_d = 1'b1;
            end
            case (state_q)
                S_START: if (bit_end) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                end
                S_DATA: if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: if (bit_end) state_d = S_STOP;
`endif
                S_STOP: if (bit_end) begin
                    // Chain the next frame on the stop-bit wrap so no idle bit appears.
                    if (hold_full_q) begin
                        load        = 1'b1;
                        load_data   = hold_q;
                        hold_full_d = 1'b0;
                    end else if (accept) begin
                        load        = 1'b1;
                        hold_full_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (load) begin
            shift_d = load_data;
            state_d = S_START;
            cnt_d   = '0;
`ifdef UART_TX_PARITY_EN
            par_d   = ^load_data;
`endif
        end

        // Line level follows the next state so tx changes on the same edge as the state.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = par_d;
`endif
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign tx           = tx_q;
    assign tx_busy      = busy_q;
    assign bus.tx_ready = !hold_full_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4; parity cases run when UART_TX_PARITY_EN is defined.
module tb_uart_tx;
    localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned FB = 11;
`else
    localparam int unsigned FB = 10;
`endif

    logic clk;
    logic rst;
    logic tx;
    logic tx_busy;
    int   checks;
    int   passes;

    uart_tx_if bus_if ();

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_if),
        .tx      (tx),
        .tx_busy (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_tx"}, tx, 1'b1);
        chk({tag, "_busy"}, tx_busy, 1'b0);
        chk({tag, "_ready"}, bus_if.tx_ready, 1'b1);
    endtask

    // Called #1 after the edge that started the frame. tx_ready is expected low for
    // frame cycles [rlo_from, rlo_to); tx_valid stays high with scrambled data for
    // cycles [1, stall_to) and drops from stall_to onward.
    task automatic frame(input string tag, input logic [7:0] b,
                         input int rlo_from, input int rlo_to, input int stall_to);
        logic [10:0] bits;
        bits      = '1;
        bits[0]   = 1'b0;
        bits[8:1] = b;
`ifdef UART_TX_PARITY_EN
        bits[9]   = ^b;
`endif
        for (int i = 0; i < int'(FB * CPB); i++) begin
            chk({tag, "_tx"}, tx, bits[i / CPB]);
            chk({tag, "_busy"}, tx_busy, 1'b1);
            chk({tag, "_ready"}, bus_if.tx_ready, !(i >= rlo_from && i < rlo_to));
            if (i >= stall_to) bus_if.tx_valid = 1'b0;
            else if (i >= 1) bus_if.tx_data = 8'($urandom);
            step();
        end
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rst = 1'b1;
        bus_if.tx_valid = 1'b0;
        bus_if.tx_data  = 8'h00;

        // Reset held for three cycles, then released.
        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle("reset");
        end
        rst = 1'b0;
        step();
        chk_idle("post_reset");

        // Single byte 0x55 from idle.
        bus_if.tx_data  = 8'h55;
        bus_if.tx_valid = 1'b1;
        step();
        frame("single55", 8'h55, 0, 0, 0);
        chk_idle("after55");
        step();
        chk_idle("idle55");

        // Back-to-back 0xA5 then 0x3C, producer stalled with changing data while hold is full.
        bus_if.tx_data  = 8'hA5;
        bus_if.tx_valid = 1'b1;
        step();
        bus_if.tx_data  = 8'h3C;
        frame("b2b_a5", 8'hA5, 1, int'(FB * CPB), int'(FB * CPB) - 1);
        frame("b2b_3c", 8'h3C, 0, 0, 0);
        chk_idle("after_b2b");
        step();
        chk_idle("idle_b2b");

        // Reset during data bit 3 of 0xFF with 0x81 pending in hold.
        bus_if.tx_data  = 8'hFF;
        bus_if.tx_valid = 1'b1;
        step();
        bus_if.tx_data  = 8'h81;
        step();
        bus_if.tx_valid = 1'b0;
        repeat (16) step();
        chk("mid_tx", tx, 1'b1);
        chk("mid_busy", tx_busy, 1'b1);
        chk("mid_ready", bus_if.tx_ready, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle("rst_mid");
        for (int i = 0; i < int'(FB * CPB) + 8; i++) begin
            step();
            chk({"quiet", $sformatf("%0d", i), "_tx"}, tx, 1'b1);
            chk("quiet_busy", tx_busy, 1'b0);
        end

`ifdef UART_TX_PARITY_EN
        bus_if.tx_data  = 8'h07;
        bus_if.tx_valid = 1'b1;
        step();
        frame("par07", 8'h07, 0, 0, 0);
        chk_idle("after07");
        bus_if.tx_data  = 8'h03;
        bus_if.tx_valid = 1'b1;
        step();
        for (int i = 0; i < 36; i++) begin
            bus_if.tx_valid = 1'b0;
            step();
        end
        chk("par03_bit", tx, 1'b0);
        repeat (8) step();
        chk_idle("after03");
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter: accepts bytes over a valid/ready handshake and shifts each one out on a single line as an 8N1 frame (start bit, eight data bits LSB first, stop bit). It is the transmit-side counterpart of the UART receive path in the same design and uses the same line convention: idle high, start bit low. A one-deep holding register allows back-to-back frames with no idle gap between them.

## Interface
- CLKS_PER_BIT, default 16: clock cycles per serial bit. Legal values are ≥ 2. The bit counter width is $clog2(CLKS_PER_BIT).
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- tx_data  input  8  byte to send. Sampled only on an accepting edge.
- tx_valid  input  1  producer has a byte on tx_data.
- tx_ready  output  1  holding register is empty; a byte can be accepted.
- tx  output  1  serial line, registered. Idle = 1.
- tx_busy  output  1  a frame is on the line (start through stop, inclusive).

## Operation
- **Accept condition:** tx_valid && tx_ready at a rising edge.
  - Shifter idle and hold empty: the byte loads directly into the shifter.
  - Otherwise: the byte loads into the hold register, and tx_ready deasserts.
- **State machine:** IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE: tx=1. Go to START when a byte is loaded.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit. Bit index runs 0..7, then go to PARITY or STOP.
  - PARITY: tx=even parity bit for CLKS_PER_BIT cycles.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
  - End of STOP, hold full: move the hold register into the shifter, go to START, set tx_ready=1. No idle cycle is inserted.
  - End of STOP, hold empty but an accept happens on that same edge: the accepted byte goes straight into the shifter and START follows with zero gap.
  - End of STOP, otherwise: go to IDLE.
- **Counters:** the bit-time counter counts 0..CLKS_PER_BIT-1 and wraps; the bit transition happens on the wrap. The bit index is 3 bits.
- **Hold register:** holds one byte. tx_ready = !hold_full, so the producer can never overwrite a pending byte.
- **Stalled producer:** tx_valid held high while tx_ready=0 causes no acceptance and no side effect.

## Timing
- **Reset values:** tx=1, tx_busy=0, tx_ready=1. State is IDLE, counters are 0, and the hold register is empty.
- **Latency:** for an accept at edge N with the block idle, tx=0 and tx_busy=1 are visible immediately after edge N.
- **Frame length:** 10·CLKS_PER_BIT cycles (11·CLKS_PER_BIT with parity). tx_busy falls after the last STOP cycle unless another frame follows.
- **tx_ready timing:**
  - Falls the cycle after an accept into the hold register.
  - Rises the cycle after the hold register is transferred into the shifter.
  - Stays high throughout a single frame that bypassed the hold register.
- **Reset mid-frame:** at the reset edge, tx=1 and tx_busy=0. The frame is truncated, the pending hold byte is discarded, and tx_ready=1. Reset takes priority over a simultaneous accept.
- **Output glitches:** tx is driven from a flop and never glitches.

## Configuration
- **UART_TX_PARITY_EN defined:**
  - A PARITY state is inserted between DATA and STOP.
  - The parity bit is ^data (even parity), so the total count of ones across data and parity is even.
  - The frame is 11 bits.
- **UART_TX_PARITY_EN undefined:** no PARITY state exists, and the frame is 10 bits (8N1).
- The interface is identical in both builds.

## Test plan
- **Reset state:** assert rst for 3 cycles. → tx=1, tx_busy=0, tx_ready=1 on every cycle of and after reset.
- **Single byte:** CLKS_PER_BIT=4, send 0x55 when idle. → Immediately after the accept edge, tx emits 0, 1,0,1,0,1,0,1,0, 1, each bit for exactly 4 cycles. tx_busy is high for 40 cycles, then tx=1 idle.
- **Back-to-back:** send 0xA5, then 0x3C on the next cycle. → tx_ready is low until 0x3C moves to the shifter at the end of the first frame. The two frames are contiguous, 80 cycles total with no idle bit. The second frame's data bits read 0,0,1,1,1,1,0,0.
- **Stalled producer:** hold tx_valid=1 with 0x3C while the hold register is full, changing tx_data each cycle. → No extra accept occurs, and the transmitted byte is the value present on the accepting edge.
- **Reset mid-frame:** pulse rst during the DATA bit 3 of 0xFF with a byte pending in hold. → tx=1, tx_busy=0, tx_ready=1 the cycle after reset. No further frame is emitted.
- **Parity (UART_TX_PARITY_EN):** send 0x07. → The parity bit is 1 and the frame is 44 cycles at CLKS_PER_BIT=4. Sending 0x03 → the parity bit is 0.
